// File: rtl/pwm_duty_sequencer.sv
// Button/breathe controlled PWM sequencer with double-buffered duty and period-aligned updates.
// Define PWM_BREATHE_EN to add the BREATHE_UP/BREATHE_DOWN triangle ramp modes.
module pwm_duty_sequencer #(
    parameter int WIDTH        = 5,
    parameter int PRESCALE     = 11,
    parameter int RAMP_PERIODS = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_mode,
    output logic             pwm_out,
    output logic [WIDTH-1:0] duty,
    output logic             period_start,
    output logic [1:0]       mode
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        MANUAL       = 2'd1,
        BREATHE_UP   = 2'd2,
        BREATHE_DOWN = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] DUTY_MAX = '1;

    if (RAMP_PERIODS < 1) begin : g_ramp_chk
        $error("RAMP_PERIODS must be at least 1");
    end

    state_e                state_q, state_d;
    logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d, sync2d_q, sync2d_d;
    logic [PRESCALE-1:0]   presc_q, presc_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      shadow_q, shadow_d;
    logic [WIDTH-1:0]      duty_act_q, duty_act_d;
    logic                  pwm_q, pwm_d;
    logic [2:0]            press;
    logic                  up_p, down_p, mode_p;
    logic                  run, tick, wrap;

    // bit 0 up, bit 1 down, bit 2 mode
    always_comb begin
        sync1_d  = {btn_mode, btn_down, btn_up};
        sync2_d  = sync1_q;
        sync2d_d = sync2_q;
    end

    assign press  = sync2_q & ~sync2d_q;
    assign up_p   = press[0];
    assign down_p = press[1];
    assign mode_p = press[2];

    assign run  = (state_q != IDLE);
    assign tick = run && (presc_q == '1);
    assign wrap = tick && (cnt_q == '1);

`ifdef PWM_BREATHE_EN
    localparam int SW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    logic [SW-1:0] step_q, step_d;
    logic          ramp_step;

    assign ramp_step = wrap && (step_q == SW'(RAMP_PERIODS - 1));
`endif

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (mode_p) state_d = MANUAL;
            end
            MANUAL: begin
                if (mode_p) begin
`ifdef PWM_BREATHE_EN
                    state_d = BREATHE_UP;
`else
                    state_d = IDLE;
`endif
                end else if (up_p && !down_p && shadow_q != DUTY_MAX) begin
                    shadow_d = shadow_q + 1'b1;
                end else if (down_p && !up_p && shadow_q != '0) begin
                    shadow_d = shadow_q - 1'b1;
                end
            end
`ifdef PWM_BREATHE_EN
            // entering a ramp already at the end just turns around without a step
            BREATHE_UP: begin
                if (mode_p) begin
                    state_d = IDLE;
                end else if (ramp_step) begin
                    if (shadow_q != DUTY_MAX) shadow_d = shadow_q + 1'b1;
                    if (shadow_d == DUTY_MAX) state_d = BREATHE_DOWN;
                end
            end
            BREATHE_DOWN: begin
                if (mode_p) begin
                    state_d = IDLE;
                end else if (ramp_step) begin
                    if (shadow_q != '0) shadow_d = shadow_q - 1'b1;
                    if (shadow_d == '0) state_d = BREATHE_UP;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef PWM_BREATHE_EN
    always_comb begin
        step_d = step_q;
        if ((state_q == BREATHE_UP || state_q == BREATHE_DOWN) && wrap)
            step_d = ramp_step ? '0 : step_q + 1'b1;
        if (state_d != state_q) step_d = '0;
    end
`endif

    always_comb begin
        presc_d    = presc_q + 1'b1;
        cnt_d      = tick ? cnt_q + 1'b1 : cnt_q;
        duty_act_d = duty_act_q;
        pwm_d      = run && (cnt_q < duty_act_q);
        // the active duty only moves on a wrap or when counting (re)starts
        if (wrap || (state_q == IDLE && state_d != IDLE)) duty_act_d = shadow_q;
        if (state_d == IDLE) begin
            presc_d = '0;
            cnt_d   = '0;
            pwm_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync2d_q   <= '0;
            presc_q    <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync2d_q   <= sync2d_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

`ifdef PWM_BREATHE_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) step_q <= '0;
        else        step_q <= step_d;
    end
`endif

    assign pwm_out      = pwm_q;
    assign duty         = shadow_q;
    assign period_start = wrap;
    assign mode         = state_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: WIDTH=5, PRESCALE=2 (128-CLK period), RAMP_PERIODS=1.
module tb_pwm_duty_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_mode = 1'b0;
    logic       pwm_out, period_start;
    logic [4:0] duty;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;
    int hi;
    int exp_duty;

    pwm_duty_sequencer #(.WIDTH(5), .PRESCALE(2), .RAMP_PERIODS(1)) dut (
        .CLK(clk), .RST_N(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_mode(btn_mode),
        .pwm_out(pwm_out), .duty(duty), .period_start(period_start), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // returns on the negedge just after the wrap edge
    task automatic wait_wrap(input string tag);
        int n = 0;
        while (period_start !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (period_start !== 1'b1) chk(tag, 0, 1);
        @(negedge clk);
    endtask

    task automatic count_hi(input int n, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h += int'(pwm_out);
        end
    endtask

    task automatic count_ps(input int n, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h += int'(period_start);
        end
    endtask

    task automatic press(input int which);
        case (which)
            0: btn_up = 1'b1;
            1: btn_down = 1'b1;
            default: btn_mode = 1'b1;
        endcase
        repeat (3) @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulses(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) btn_up = 1'b1; else btn_down = 1'b1;
            @(negedge clk);
            btn_up = 1'b0; btn_down = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // 1. reset and IDLE
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mode", mode, 0);
        chk("rst_duty", duty, 0);
        chk("rst_pwm", pwm_out, 0);
        count_ps(500, hi);
        chk("idle_no_period", hi, 0);

        // 2. manual stepping
        press(2);
        chk("manual_mode", mode, 1);
        for (int i = 0; i < 8; i++) press(0);
        chk("duty8", duty, 8);
        wait_wrap("wrap_d8");
        count_hi(128, hi);
        chk("hi_d8", hi, 32);
        for (int i = 0; i < 10; i++) press(1);
        chk("duty_sat0", duty, 0);
        wait_wrap("wrap_d0");
        count_hi(128, hi);
        chk("hi_d0", hi, 0);

        // 3. saturation high and simultaneous up+down
        pulses(0, 40);
        chk("duty_sat31", duty, 31);
        wait_wrap("wrap_d31");
        count_hi(128, hi);
        chk("hi_d31", hi, 124);
        btn_up = 1'b1; btn_down = 1'b1;
        @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (5) @(negedge clk);
        chk("duty_both", duty, 31);

        // 4. glitch-free update: 4 -> 20 starting at cnt=10
        pulses(1, 27);
        chk("duty4", duty, 4);
        wait_wrap("wrap_d4a");
        wait_wrap("wrap_d4b");
        hi = 0;
        for (int i = 1; i <= 126; i++) begin
            @(negedge clk);
            hi += int'(pwm_out);
            btn_up = (i >= 40 && i < 72 && (i % 2) == 0);
        end
        btn_up = 1'b0;
        chk("hi_keep16", hi, 16);
        chk("duty20", duty, 20);
        wait_wrap("wrap_d20");
        count_hi(128, hi);
        chk("hi_d20", hi, 80);

        pulses(0, 10);
        chk("duty30", duty, 30);

`ifdef PWM_BREATHE_EN
        // 5. breathe triangle
        wait_wrap("wrap_pre_br");
        press(2);
        chk("br_up_mode", mode, 2);
        chk("br_up_duty", duty, 30);
        wait_wrap("wrap_br1");
        chk("br_top_duty", duty, 31);
        chk("br_top_mode", mode, 3);
        for (int i = 0; i < 15; i++) wait_wrap("wrap_br_dn");
        chk("br_mid_duty", duty, 16);
        chk("br_mid_mode", mode, 3);
        for (int i = 0; i < 16; i++) wait_wrap("wrap_br_dn2");
        chk("br_bot_duty", duty, 0);
        chk("br_bot_mode", mode, 2);
        for (int i = 0; i < 5; i++) wait_wrap("wrap_br_up");
        chk("br_up5", duty, 5);
        exp_duty = 5;
`else
        wait_wrap("wrap_pre_idle");
        exp_duty = 30;
`endif
        // 6. IDLE entry right after a wrap, while pwm would be high
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_mode", mode, 0);
        chk("idle_pwm", pwm_out, 0);
        chk("idle_duty", duty, exp_duty);
        btn_mode = 1'b0;
        repeat (3) @(negedge clk);
        count_ps(200, hi);
        chk("idle_no_ps", hi, 0);

        press(2);
        chk("rerun_mode", mode, 1);
        wait_wrap("wrap_rerun");
        count_hi(128, hi);
        chk("hi_rerun", hi, exp_duty * 4);

        wait_wrap("wrap_pre_rst");
        repeat (2) @(negedge clk);
        chk("pre_rst_pwm", pwm_out, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_mode", mode, 0);
        chk("mid_rst_duty", duty, 0);
        chk("mid_rst_pwm", pwm_out, 0);
        chk("mid_rst_ps", period_start, 0);
        rst_n = 1'b1;
        count_ps(200, hi);
        chk("post_rst_no_ps", hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
